// File: rtl/echo_tester.sv
// Bus initiator that runs a write/readback self-test against a two-register
// echo responder and reports pass, error count and timeout status.
module echo_tester #(
    parameter logic [31:0] PAT1       = 32'hffff4444,
    parameter logic [31:0] PAT2       = 32'h4444ffff,
    parameter int unsigned ITERATIONS = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  err_count,
    output logic        stb,
    output logic        we,
    output logic        addr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    input  logic        ack
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2, FIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   iter_nx;
    logic [31:0]        p1, p2;
    logic               busy_d, done_d, pass_d, timeout_d;
    logic               stb_d, we_d, addr_d;
    logic [31:0]        data_d;
    logic [7:0]         err_d;

    // Rotate left by s bits using a doubled word
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] e);
        return (e == 8'hff) ? e : e + 8'd1;
    endfunction

    assign iter_nx = iter_q + CNT_W'(1);
    assign p1      = rotl(PAT1, iter_q[4:0]);
    assign p2      = rotl(PAT2, iter_q[4:0]);

    // Next-state and next-output logic; bus values for an access are loaded
    // on the edge that completes the previous one so they stay stable while waiting
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        wait_d    = wait_q;
        busy_d    = busy;
        done_d    = 1'b0;
        pass_d    = pass;
        timeout_d = timeout;
        err_d     = err_count;
        stb_d     = stb;
        we_d      = we;
        addr_d    = addr;
        data_d    = data_out;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WR1;
                    iter_d    = '0;
                    wait_d    = '0;
                    err_d     = 8'd0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = 1'b0;
                    data_d    = PAT1;
                end
            end
            WR1, WR2, RD1, RD2: begin
                if (ack) begin
                    wait_d = '0;
                    case (state_q)
                        WR1: begin
                            state_d = WR2;
                            addr_d  = 1'b1;
                            data_d  = p2;
                        end
                        WR2: begin
                            state_d = RD1;
                            we_d    = 1'b0;
                            addr_d  = 1'b0;
                            data_d  = 32'd0;
                        end
                        RD1: begin
                            state_d = RD2;
                            addr_d  = 1'b1;
                            if (data_in != {16'h0, p1[15:0]}) err_d = sat_inc(err_count);
                        end
                        default: begin
                            if (data_in != {16'h0, p2[31:16]}) err_d = sat_inc(err_count);
                            if (iter_q < CNT_W'(ITERATIONS - 1)) begin
                                state_d = WR1;
                                iter_d  = iter_nx;
                                we_d    = 1'b1;
                                addr_d  = 1'b0;
                                data_d  = rotl(PAT1, iter_nx[4:0]);
                            end else begin
                                state_d = FIN;
                                stb_d   = 1'b0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                we_d    = 1'b0;
                                addr_d  = 1'b0;
                                data_d  = 32'd0;
                                pass_d  = (err_d == 8'd0) && !timeout;
                            end
                        end
                    endcase
                end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                    // Responder never answered: abandon the run
                    state_d   = FIN;
                    stb_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    we_d      = 1'b0;
                    addr_d    = 1'b0;
                    data_d    = 32'd0;
                    timeout_d = 1'b1;
                    err_d     = sat_inc(err_count);
                    pass_d    = 1'b0;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            wait_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= 8'd0;
            stb       <= 1'b0;
            we        <= 1'b0;
            addr      <= 1'b0;
            data_out  <= 32'd0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            wait_q    <= wait_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            timeout   <= timeout_d;
            err_count <= err_d;
            stb       <= stb_d;
            we        <= we_d;
            addr      <= addr_d;
            data_out  <= data_d;
        end
    end

endmodule
